// File: rtl/pll_seq_pkg.sv
// Shared state encoding and output widths for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  localparam int RETRY_W = 4;
  localparam int LOL_W   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock with
// a timeout and bounded retries, then releases the downstream reset.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 50,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 7
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               restart,
  input  logic               locked_in,
  output logic               pll_rst,
  output logic               rst_out,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOL_W-1:0]   lol_cnt,
  output logic [2:0]         state
);

  localparam int PW = $clog2(RST_PULSE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [PW-1:0]      P_LAST    = PW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0]      TO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]      ST_LAST   = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  function automatic logic [LOL_W-1:0] lol_sat_inc(input logic [LOL_W-1:0] v);
    return (v == {LOL_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic lk;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (locked_in),
    .q_o (lk)
  );

  seq_state_e         state_q, state_d;
  logic [PW-1:0]      pulse_q, pulse_d;
  logic [TW-1:0]      to_q, to_d;
  logic [SW-1:0]      st_q, st_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOL_W-1:0]   lol_q, lol_d;
  logic               to_expired;

  always_comb begin
    state_d    = state_q;
    pulse_d    = pulse_q;
    to_d       = to_q;
    st_d       = st_q;
    retry_d    = retry_q;
    lol_d      = lol_q;
    to_expired = 1'b0;
    if (restart) begin
      // Restart wins over everything, including a loss of lock seen this cycle
      state_d = ST_PLL_RST;
      pulse_d = '0;
      to_d    = '0;
      st_d    = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (pulse_q == P_LAST) begin
            state_d = ST_WAIT_LOCK;
            pulse_d = '0;
            to_d    = '0;
            st_d    = '0;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          to_d = to_q + 1'b1;
          if (to_q == TO_LAST) begin
            to_expired = 1'b1;
          end else if (lk) begin
            // The cycle lk is first seen high already counts toward stability
            if (LOCK_STABLE_CYC <= 1) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_STABLE;
              st_d    = SW'(1);
            end
          end
        end
        ST_STABLE: begin
          to_d = to_q + 1'b1;
          if (lk && (st_q == ST_LAST)) begin
            state_d = ST_RUN;
            st_d    = '0;
          end else if (to_q == TO_LAST) begin
            to_expired = 1'b1;
          end else if (!lk) begin
            state_d = ST_WAIT_LOCK;
            st_d    = '0;
          end else begin
            st_d = st_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            state_d = ST_PLL_RST;
            pulse_d = '0;
            retry_d = '0;
            lol_d   = lol_sat_inc(lol_q);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
          pulse_d = '0;
        end
      endcase
      if (to_expired) begin
        pulse_d = '0;
        to_d    = '0;
        st_d    = '0;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_PLL_RST;
        end else begin
          state_d = ST_FAIL;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they line up with state_q
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= ST_PLL_RST;
      pulse_q <= '0;
      to_q    <= '0;
      st_q    <= '0;
      retry_q <= '0;
      lol_q   <= '0;
      pll_rst <= 1'b1;
      rst_out <= 1'b1;
      ready   <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      to_q    <= to_d;
      st_q    <= st_d;
      retry_q <= retry_d;
      lol_q   <= lol_d;
      pll_rst <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      rst_out <= (state_d != ST_RUN);
      ready   <= (state_d == ST_RUN);
      fail    <= (state_d == ST_FAIL);
    end
  end

  assign retry_cnt = retry_q;
  assign lol_cnt   = lol_q;
  assign state     = state_q;

endmodule
